// File: rtl/add_sub_seq_pkg.sv
// ----------------------------------------------------------------------------
// add_sub_seq_pkg
// Shared definitions for the sequential multi-byte add/subtract engine:
//   - operation encodings (same as the single-cycle ADD_SUB block)
//   - FSM state encodings
//   - signed-overflow helper used when the final byte is produced
// ----------------------------------------------------------------------------
package add_sub_seq_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement overflow: both operands (B already conditionally
    // inverted) agree in sign but the sum's sign differs from them.
    function automatic logic signed_ovf(input logic a_msb,
                                        input logic b_msb,
                                        input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/add_sub_seq_if.sv
// ----------------------------------------------------------------------------
// add_sub_seq_if
// Request/response bundle of the add/sub engine.
//   request : in_valid, in_ready, in_a, in_b, add_or_sub
//   response: out_valid, out_ready, out_res, out_c, out_v, out_z
// modport master : issue side (drives requests, consumes responses)
// modport slave  : engine side
// ----------------------------------------------------------------------------
interface add_sub_seq_if #(parameter int W = 32);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         add_or_sub;

    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_res;
    logic         out_c;
    logic         out_v;
    logic         out_z;

    modport master (
        output in_valid, in_a, in_b, add_or_sub, out_ready,
        input  in_ready, out_valid, out_res, out_c, out_v, out_z
    );

    modport slave (
        input  in_valid, in_a, in_b, add_or_sub, out_ready,
        output in_ready, out_valid, out_res, out_c, out_v, out_z
    );

endinterface

// File: rtl/add_sub_seq_slice.sv
// ----------------------------------------------------------------------------
// add_sub_slice
// Combinational 8-bit carry-chained add/subtract slice.
//   a, b   : operand bytes
//   sub    : OP_SUB inverts b (caller supplies cin=1 on the first byte)
//   cin    : carry from the previous byte
//   s      : sum byte
//   cout   : carry out (for subtract, 1 means no borrow)
//   a_msb  : bit 7 of a
//   b_msb  : bit 7 of the effective (possibly inverted) b, for overflow
// ----------------------------------------------------------------------------
module add_sub_slice
    import add_sub_seq_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       sub,
    input  logic       cin,
    output logic [7:0] s,
    output logic       cout,
    output logic       a_msb,
    output logic       b_msb
);

    logic [7:0] b_eff;
    logic [8:0] sum;

    // Conditional inversion of B followed by a 9-bit add that exposes carry.
    always_comb begin
        b_eff = (sub == OP_SUB) ? ~b : b;
        sum   = {1'b0, a} + {1'b0, b_eff} + {8'b0000_0000, cin};
        s     = sum[7:0];
        cout  = sum[8];
        a_msb = a[7];
        b_msb = b_eff[7];
    end

endmodule

// File: rtl/add_sub_seq.sv
// ----------------------------------------------------------------------------
// add_sub_seq
// Multi-byte sequential add/subtract engine. One byte per cycle, LSB first,
// through add_sub_slice. Result and C/V/Z flags are published on a
// valid/ready response port.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : add_sub_seq_if.slave (request and response handshakes)
// Timing: accept edge -> NBYTES RUN edges (one byte each) -> DONE. The first
// DONE edge publishes result and flags (Z is taken from the completed result
// register), so out_valid rises NBYTES+1 edges after the accept edge.
// ----------------------------------------------------------------------------
module add_sub_seq
    import add_sub_seq_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    add_sub_seq_if.slave  bus
);

    localparam int W    = BYTE_W * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NBYTES - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    state_e          state_q,     state_d;
    logic [IDXW-1:0] idx_q,       idx_d;
    logic [W-1:0]    a_sh_q,      a_sh_d;
    logic [W-1:0]    b_sh_q,      b_sh_d;
    logic [W-1:0]    res_sh_q,    res_sh_d;
    logic            op_q,        op_d;
    logic            carry_q,     carry_d;
    logic            v_fin_q,     v_fin_d;
    logic            in_ready_q,  in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    out_res_q,   out_res_d;
    logic            out_c_q,     out_c_d;
    logic            out_v_q,     out_v_d;
    logic            out_z_q,     out_z_d;

    logic [7:0]      slice_s;
    logic            slice_cout;
    logic            slice_a_msb;
    logic            slice_b_msb;
    logic [W-1:0]    res_shifted;

    // The slice always works on the low byte of the operand shift registers.
    add_sub_slice u_slice (
        .a     (a_sh_q[7:0]),
        .b     (b_sh_q[7:0]),
        .sub   (op_q),
        .cin   (carry_q),
        .s     (slice_s),
        .cout  (slice_cout),
        .a_msb (slice_a_msb),
        .b_msb (slice_b_msb)
    );

    // New sum byte enters at the top of the result register; after NBYTES
    // shifts byte 0 has reached the bottom.
    generate
        if (NBYTES == 1) begin : g_res_one
            assign res_shifted = slice_s;
        end else begin : g_res_multi
            assign res_shifted = {slice_s, res_sh_q[W-1:8]};
        end
    endgenerate

    // Next-state and datapath logic for the IDLE/RUN/DONE sequencer.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        op_d        = op_q;
        carry_d     = carry_q;
        v_fin_d     = v_fin_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_res_d   = out_res_q;
        out_c_d     = out_c_q;
        out_v_d     = out_v_q;
        out_z_d     = out_z_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_sh_d     = bus.in_a;
                    b_sh_d     = bus.in_b;
                    op_d       = bus.add_or_sub;
                    // Subtract is A + ~B + 1, so the op bit doubles as carry-in.
                    carry_d    = bus.add_or_sub;
                    idx_d      = {IDXW{1'b0}};
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end else begin
                    in_ready_d = 1'b1;
                end
            end

            ST_RUN: begin
                a_sh_d     = a_sh_q >> 4'd8;
                b_sh_d     = b_sh_q >> 4'd8;
                res_sh_d   = res_shifted;
                carry_d    = slice_cout;
                in_ready_d = 1'b0;
                if (idx_q == IDX_LAST) begin
                    v_fin_d = signed_ovf(slice_a_msb, slice_b_msb, slice_s[7]);
                    idx_d   = {IDXW{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                end
            end

            ST_DONE: begin
                in_ready_d = 1'b0;
                if (!out_valid_q) begin
                    // Publish everything together so out_* only ever change
                    // alongside the rising edge of out_valid.
                    out_valid_d = 1'b1;
                    out_res_d   = res_sh_q;
                    out_c_d     = carry_q;
                    out_v_d     = v_fin_q;
                    out_z_d     = (res_sh_q == {W{1'b0}});
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                idx_d       = {IDXW{1'b0}};
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any op in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= {IDXW{1'b0}};
            a_sh_q      <= {W{1'b0}};
            b_sh_q      <= {W{1'b0}};
            res_sh_q    <= {W{1'b0}};
            op_q        <= OP_ADD;
            carry_q     <= 1'b0;
            v_fin_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_res_q   <= {W{1'b0}};
            out_c_q     <= 1'b0;
            out_v_q     <= 1'b0;
            out_z_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            op_q        <= op_d;
            carry_q     <= carry_d;
            v_fin_q     <= v_fin_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_res_q   <= out_res_d;
            out_c_q     <= out_c_d;
            out_v_q     <= out_v_d;
            out_z_q     <= out_z_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_res   = out_res_q;
    assign bus.out_c     = out_c_q;
    assign bus.out_v     = out_v_q;
    assign bus.out_z     = out_z_q;

endmodule
